// File: rtl/dmem_word_arbiter.sv
// dmem_word_arbiter
// Splits 32-bit word accesses into four big-endian byte beats on a byte-wide,
// single-port synchronous memory, and arbitrates that memory between the CPU
// load/store path and the debug/loader port.
//
// Build option:
//   DMEM_ARB_DBG_PRIORITY_EN  - when defined, the debug port wins every tie and
//                               the round-robin last-grant register is removed.
//                               When undefined, ties alternate round-robin.

module dmem_word_arbiter #(
    parameter int ADDR_W  = 10,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BEAT   = 3'd1,
        S_RDWAIT = 3'd2,
        S_ACK    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Byte k of a word, most significant byte first.
    function automatic logic [7:0] beat_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-3:0] word_q, word_d;      // word index of the granted access
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              sel_q, sel_d;        // 1 = debug port owns the access
    logic [31:0]       shift_q, shift_d;    // read data assembled MSB-first
    logic              cap_q, cap_d;        // mem_rdata holds a read byte this cycle
`ifndef DMEM_ARB_DBG_PRIORITY_EN
    logic              last_q, last_d;      // 1 = debug won the last tie
`endif

    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              cpu_ack_d, cpu_err_d, dbg_ack_d, dbg_err_d;
    logic [31:0]       cpu_rdata_d, dbg_rdata_d;

    logic              grant_dbg_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic              done_s;
    logic              err_s;
    logic [31:0]       rdata_s;

    // Stall is combinational so the CPU freezes in the very cycle it requests.
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Arbitration, request latching, beat sequencing and read-byte capture.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        word_d      = word_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        shift_d     = cap_q ? {shift_q[23:0], mem_rdata} : shift_q;
        cap_d       = 1'b0;
        grant_dbg_s = 1'b0;
        req_addr_s  = '0;
`ifndef DMEM_ARB_DBG_PRIORITY_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
`ifdef DMEM_ARB_DBG_PRIORITY_EN
                    grant_dbg_s = dbg_req;
`else
                    if (cpu_req && dbg_req) begin
                        // Tie: the side that did not win the previous tie goes now.
                        grant_dbg_s = ~last_q;
                        last_d      = ~last_q;
                    end else begin
                        grant_dbg_s = dbg_req;
                    end
`endif
                    req_addr_s = grant_dbg_s ? dbg_addr : cpu_addr;
                    sel_d      = grant_dbg_s;
                    word_d     = req_addr_s[ADDR_W-1:2];
                    we_d       = grant_dbg_s ? dbg_we : cpu_we;
                    wdata_d    = grant_dbg_s ? dbg_wdata : cpu_wdata;
                    beat_d     = 2'd0;
                    shift_d    = 32'd0;
                    if (req_addr_s[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BEAT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BEAT: begin
                cap_d = ~we_q;
                if (beat_q == 2'd3) begin
                    beat_d  = 2'd0;
                    state_d = we_q ? S_ACK : S_RDWAIT;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    state_d = S_BEAT;
                end
            end
            S_RDWAIT: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next-cycle output values, derived from next state so outputs can be registered.
    always_comb begin
        mem_en_d = (state_d == S_BEAT);
        mem_we_d = mem_en_d & we_d;
        if (mem_en_d) begin
            mem_addr_d  = {word_d, beat_d};
            mem_wdata_d = we_d ? beat_byte(wdata_d, beat_d) : 8'd0;
        end else begin
            mem_addr_d  = '0;
            mem_wdata_d = 8'd0;
        end
        done_s      = (state_d == S_ACK) || (state_d == S_ERR);
        err_s       = (state_d == S_ERR);
        rdata_s     = ((state_d == S_ACK) && !we_d) ? shift_d : 32'd0;
        cpu_ack_d   = done_s & ~sel_d;
        cpu_err_d   = err_s & ~sel_d;
        cpu_rdata_d = sel_d ? 32'd0 : rdata_s;
        dbg_ack_d   = done_s & sel_d;
        dbg_err_d   = err_s & sel_d;
        dbg_rdata_d = sel_d ? rdata_s : 32'd0;
    end

    // State and registered outputs; reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= 2'd0;
            word_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            sel_q     <= 1'b0;
            shift_q   <= 32'd0;
            cap_q     <= 1'b0;
`ifndef DMEM_ARB_DBG_PRIORITY_EN
            last_q    <= ~RR_INIT;
`endif
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'd0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            dbg_rdata <= 32'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            shift_q   <= shift_d;
            cap_q     <= cap_d;
`ifndef DMEM_ARB_DBG_PRIORITY_EN
            last_q    <= last_d;
`endif
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_ack   <= cpu_ack_d;
            cpu_err   <= cpu_err_d;
            cpu_rdata <= cpu_rdata_d;
            dbg_ack   <= dbg_ack_d;
            dbg_err   <= dbg_err_d;
            dbg_rdata <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_word_arbiter.sv
// Testbench for dmem_word_arbiter: byte memory model, directed word accesses,
// expected responses queued per port and checked by an ack monitor.

module tb_dmem_word_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dbg_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int en_beats  = 0;
    int wr_beats  = 0;
    int stall_cnt = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    dmem_word_arbiter #(.ADDR_W(ADDR_W), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous byte memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Cycle counter and memory-beat counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) en_beats <= en_beats + 1;
        if (mem_en && mem_we) wr_beats <= wr_beats + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses whenever an ack is presented.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_stall) stall_cnt++;
        if (cpu_ack) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", cpu_rdata, e.rdata);
                chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                chk("cpu_ack_cycle", cyc, e.cyc);
            end
            chk("dbg_quiet_on_cpu_ack", {dbg_rdata[29:0], dbg_ack, dbg_err}, 32'd0);
            chk("no_mem_en_on_ack", {31'd0, mem_en}, 32'd0);
        end
        if (dbg_ack) begin
            if (dbg_q.size() == 0) begin
                chk("dbg_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = dbg_q.pop_front();
                chk("dbg_rdata", dbg_rdata, e.rdata);
                chk("dbg_err", {31'd0, dbg_err}, {31'd0, e.err});
                chk("dbg_ack_cycle", cyc, e.cyc);
            end
            chk("cpu_quiet_on_dbg_ack", {cpu_rdata[29:0], cpu_ack, cpu_err}, 32'd0);
            chk("no_mem_en_on_ack", {31'd0, mem_en}, 32'd0);
        end
    end

    // Issue one word access on a port, queue its expected response, hold until ack.
    task automatic access(input bit is_dbg, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit exp_err, input int lat);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        if (is_dbg) dbg_q.push_back(e);
        else        cpu_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = is_dbg ? dbg_ack : cpu_ack;
        end
        if (!got) chk(is_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
        if (is_dbg) dbg_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int s0, w0, e0;
        int c_first, d_first;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_en",    {31'd0, mem_en}, 32'd0);
        chk("reset_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr",  {22'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("reset_acks",      {28'd0, cpu_ack, cpu_err, dbg_ack, dbg_err}, 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);
        chk("reset_dbg_rdata", dbg_rdata, 32'd0);
        chk("reset_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        rst_n = 1'b1;

        // CPU write: four beats, ack at T5, stall over T0..T4.
        s0 = stall_cnt; w0 = wr_beats;
        access(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 32'd0, 1'b0, 5);
        chk("wr_mem_010", {24'd0, mem[10'h010]}, 32'h0000_00DE);
        chk("wr_mem_011", {24'd0, mem[10'h011]}, 32'h0000_00AD);
        chk("wr_mem_012", {24'd0, mem[10'h012]}, 32'h0000_00BE);
        chk("wr_mem_013", {24'd0, mem[10'h013]}, 32'h0000_00EF);
        chk("wr_write_beats", wr_beats - w0, 32'd4);
        @(negedge clk);
        chk("wr_stall_cycles", stall_cnt - s0, 32'd5);

        // CPU read back: ack at T6, no write beats, four read beats.
        s0 = stall_cnt; w0 = wr_beats; e0 = en_beats;
        access(1'b0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 6);
        chk("rd_write_beats", wr_beats - w0, 32'd0);
        chk("rd_mem_beats", en_beats - e0, 32'd4);
        @(negedge clk);
        chk("rd_stall_cycles", stall_cnt - s0, 32'd6);

        // Two ties of writes: first tie then second tie.
`ifdef DMEM_ARB_DBG_PRIORITY_EN
        c_first = 11; d_first = 5;
`else
        c_first = 5;  d_first = 11;
`endif
        fork
            access(1'b0, 1'b1, 10'h100, 32'h01020304, 32'd0, 1'b0, c_first);
            access(1'b1, 1'b1, 10'h200, 32'h0A0B0C0D, 32'd0, 1'b0, d_first);
        join
        fork
            access(1'b0, 1'b1, 10'h104, 32'h11111111, 32'd0, 1'b0, 11);
            access(1'b1, 1'b1, 10'h204, 32'h22222222, 32'd0, 1'b0, 5);
        join
        access(1'b1, 1'b0, 10'h100, 32'h0, 32'h01020304, 1'b0, 6);
        access(1'b0, 1'b0, 10'h204, 32'h0, 32'h22222222, 1'b0, 6);

        // Misaligned debug read, then the top aligned word.
        access(1'b1, 1'b1, 10'h3FC, 32'hA1B2C3D4, 32'd0, 1'b0, 5);
        e0 = en_beats;
        access(1'b1, 1'b0, 10'h013, 32'h0, 32'd0, 1'b1, 1);
        chk("err_no_mem_beats", en_beats - e0, 32'd0);
        access(1'b1, 1'b0, 10'h3FC, 32'h0, 32'hA1B2C3D4, 1'b0, 6);
        chk("top_mem_3ff", {24'd0, mem[10'h3FF]}, 32'h0000_00D4);

        // Reset in the middle of a CPU write.
        access(1'b1, 1'b1, 10'h020, 32'h55667788, 32'd0, 1'b0, 5);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem_en_before", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en_dropped", {31'd0, mem_en}, 32'd0);
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem_020", {24'd0, mem[10'h020]}, 32'h0000_0011);
        chk("abort_mem_021", {24'd0, mem[10'h021]}, 32'h0000_0022);
        chk("abort_mem_022", {24'd0, mem[10'h022]}, 32'h0000_0077);
        chk("abort_mem_023", {24'd0, mem[10'h023]}, 32'h0000_0088);
        rst_n = 1'b1;
        access(1'b0, 1'b1, 10'h020, 32'hCAFEF00D, 32'd0, 1'b0, 5);
        access(1'b0, 1'b0, 10'h020, 32'h0, 32'hCAFEF00D, 1'b0, 6);

        repeat (4) @(posedge clk);
        chk("cpu_queue_drained", cpu_q.size(), 32'd0);
        chk("dbg_queue_drained", dbg_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_word_arbiter.md
Name: dmem_word_arbiter

Overview:
- Sequences 32-bit word accesses onto the byte-wide, single-port data memory (1024 x 8).
- Arbitrates that memory between two requesters: the CPU load/store path and the debug/loader port used by the bench to preload and inspect memory.
- Each word access is split into four big-endian byte beats.
- The CPU is stalled through `cpu_stall`, which the top level uses to gate `enable`, until its access completes.

Parameters:
- ADDR_W, 10, byte address width of the data memory (depth = 2**ADDR_W bytes).
- RR_INIT, 0, grant winner after reset on a tie: 0 = CPU, 1 = debug.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  1 = store word, 0 = load word
- cpu_addr  input  ADDR_W  byte address of the word
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data, valid while cpu_ack=1
- cpu_ack  output  1  one-cycle completion pulse
- cpu_err  output  1  misaligned-address flag, valid with cpu_ack
- cpu_stall  output  1  cpu_req & ~cpu_ack
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err  same widths and meaning as the cpu_* ports, for the debug port
- mem_en  output  1  byte memory access strobe
- mem_we  output  1  byte write enable
- mem_addr  output  ADDR_W  byte address
- mem_wdata  output  8  byte write data
- mem_rdata  input  8  byte read data, synchronous, valid one cycle after mem_en

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; beat counter 0; last-grant register = !RR_INIT, so RR_INIT wins the first tie.
- Reset mid-operation: the access is aborted immediately (asynchronous). mem_en drops without waiting for a clock, no ack is issued, and partial writes already performed remain in memory.
- Requests are sampled only in IDLE. At grant, addr, we and wdata are latched; later changes to the requester's inputs are ignored until its ack.

FSM states:
- IDLE: no requests -> stay.
  - One request -> grant it.
  - Both requests -> grant the requester that was not granted last (round-robin); update last-grant.
  - Granted with addr[1:0] != 0 -> go to ERR.
  - Otherwise -> go to BEAT.
- BEAT: four cycles, beat k = 0..3.
  - mem_en=1, mem_addr = {addr[ADDR_W-1:2], k}.
  - mem_we = latched we; mem_wdata = wdata[31-8k -: 8] (byte k = most significant first, big-endian).
  - After k=3: write -> ACK; read -> RDWAIT.
- RDWAIT: one cycle, mem_en=0. Captures the byte-3 read data.
  - Read bytes are captured into a 32-bit shift register in the cycle after each beat, assembled MSB-first.
- ACK: one cycle; the granted requester's ack=1 and rdata = assembled word (rdata is 0 for writes) -> IDLE.
- ERR: one cycle; ack=1, err=1, no memory access -> IDLE.

Latency and handshake:
- Latency from the cycle a request is sampled in IDLE (T0):
  - write ack at T5
  - read ack at T6
  - misaligned ack at T1
- The ungranted requester sees stall only.
- A requester must drop or renew its request in the cycle after ack. Because ack returns the FSM to IDLE, a still-high request is re-arbitrated as a new access.
- mem_en is never asserted outside BEAT.
- Only one requester is ever granted at a time; the non-granted ack/err/rdata outputs are 0.
- Address range: the top aligned word (2**ADDR_W - 4) is valid. Beat addresses never wrap because only aligned words are accepted.

Optional Feature:
- DMEM_ARB_DBG_PRIORITY_EN defined: the debug port has strict priority on ties, and the round-robin register is unused.
  - A CPU request waits while dbg_req stays high, and is granted in the first IDLE cycle where dbg_req=0.
- Not defined: round-robin as specified above.

Test Plan:
- CPU write 0xDEADBEEF to 0x010 -> mem bytes 0x010..0x013 = DE, AD, BE, EF; cpu_ack at T5; cpu_stall high T0..T4.
- CPU read 0x010 after the write above -> cpu_rdata = 0xDEADBEEF with cpu_ack at T6; mem_we=0 on all 4 beats.
- cpu_req and dbg_req raised together after reset (RR_INIT=0), both writes -> CPU served first, then debug (dbg_ack 6 cycles after cpu_ack). Repeat the tie -> debug served first. With DMEM_ARB_DBG_PRIORITY_EN defined, debug is served first both times.
- dbg read at 0x013 -> dbg_ack=1 and dbg_err=1 at T1, mem_en stays 0; next dbg read at 0x3FC returns the bytes preloaded at 0x3FC..0x3FF.
- rst_n low after beat 1 of a CPU write of 0x11223344 to 0x020 -> mem_en 0 immediately, no cpu_ack; memory holds 11, 22 at 0x020/0x021, old data at 0x022/0x023; after release, the next write/read completes normally.
